directory_controller: RTL

- Home-node directory and memory controller for the MSI directory protocol. Sits directly downstream of the two processor L1 caches (P1, P2).
- Consumes their miss/invalidate requests (Signal, AddressLista, DataLista, WriteBack) and returns block data on AddressMemory/DataMemory.
- Keeps per-block directory state and sharer vector, and sequences invalidations and owner write-back fetches.

---
 rtl/directory_controller.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/directory_controller.sv
// Home-node MSI directory and memory controller for two L1 caches (P1, P2).
// Tracks per-block state/sharers, sequences invalidations and owner fetches, and returns block data.
module directory_controller #(
   parameter int NUM_BLOCKS  = 8,
   parameter int INV_TIMEOUT = 15
) (
   input  logic       Clock,
   input  logic       Reset_n,
   input  logic       ReqValid,
   output logic       ReqReady,
   input  logic [1:0] Signal,
   input  logic       ReqProc,
   input  logic [3:0] AddressLista,
   input  logic [3:0] DataLista,
   input  logic [1:0] WriteBack,
   input  logic [1:0] InvAck,
   output logic       InvValid,
   output logic [1:0] InvTarget,
   output logic       FetchReq,
   output logic [3:0] InvAddress,
   output logic       RespValid,
   output logic       RespProc,
   output logic [3:0] AddressMemory,
   output logic [3:0] DataMemory,
   output logic       ErrFlag
);

   localparam int CW = $clog2(INV_TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE, LOOKUP, INVAL, WAIT_ACK, FETCH, WAIT_WB, RESPOND
   } ctrlState_t;

   typedef enum logic [1:0] {
      UNCACHED = 2'b00,
      SHARED   = 2'b01,
      MODIFIED = 2'b10
   } dirState_t;

   localparam logic [1:0] SIG_READ = 2'b01;

   ctrlState_t state;
   dirState_t  dirState   [16];
   logic [1:0] dirSharers [16];
   logic [3:0] memData    [16];

   logic [1:0]    reqSignal;
   logic          reqProcL;
   logic [3:0]    reqAddr;
   logic [1:0]    waitMask;
   logic [1:0]    ackSeen;
   logic [CW-1:0] waitCount;
   dirState_t     pendState;
   logic [1:0]    pendSharers;

   logic       wbValid;
   logic       wbAddrValid;
   logic       addrValid;
   logic [1:0] reqMask;
   dirState_t  curState;
   logic [1:0] curSharers;
   logic [1:0] otherSharers;
   logic       isOwner;
   logic       timedOut;
   logic       acksDone;
   logic       wbMatch;

   assign wbValid      = (WriteBack == 2'b01);
   assign wbAddrValid  = (AddressLista != 4'd0) && (AddressLista <= 4'(NUM_BLOCKS));
   assign addrValid    = (reqAddr != 4'd0) && (reqAddr <= 4'(NUM_BLOCKS));
   assign reqMask      = reqProcL ? 2'b10 : 2'b01;
   assign curState     = dirState[reqAddr];
   assign curSharers   = dirSharers[reqAddr];
   assign otherSharers = curSharers & ~reqMask;
   assign isOwner      = (curState == MODIFIED) && (curSharers == reqMask);
   assign timedOut     = (waitCount == CW'(INV_TIMEOUT - 1));
   assign acksDone     = (((ackSeen | InvAck) & waitMask) == waitMask);
   assign wbMatch      = wbValid && (AddressLista == reqAddr);

   // A pending write-back blocks acceptance for that cycle, so ReqReady follows it directly.
   assign ReqReady = (state == IDLE) && !wbValid;

   // Whole controller: request sequencing, directory/memory updates and registered outputs.
   // The timeout fires on the INV_TIMEOUT-th wait cycle without completion.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state         <= IDLE;
         InvValid      <= 1'b0;
         InvTarget     <= 2'b00;
         FetchReq      <= 1'b0;
         InvAddress    <= 4'd0;
         RespValid     <= 1'b0;
         RespProc      <= 1'b0;
         AddressMemory <= 4'd0;
         DataMemory    <= 4'd0;
         ErrFlag       <= 1'b0;
         reqSignal     <= 2'b00;
         reqProcL      <= 1'b0;
         reqAddr       <= 4'd0;
         waitMask      <= 2'b00;
         ackSeen       <= 2'b00;
         waitCount     <= '0;
         pendState     <= UNCACHED;
         pendSharers   <= 2'b00;
         for (int a = 0; a < 16; a++) begin
            dirState[a]   <= UNCACHED;
            dirSharers[a] <= 2'b00;
            memData[a]    <= 4'(a);
         end
      end else begin
         case (state)
            IDLE: begin
               if (wbValid) begin
                  if (wbAddrValid) begin
                     memData[AddressLista]    <= DataLista;
                     dirState[AddressLista]   <= UNCACHED;
                     dirSharers[AddressLista] <= 2'b00;
                  end
               end else if (ReqValid && (Signal != 2'b00)) begin
                  reqSignal <= Signal;
                  reqProcL  <= ReqProc;
                  reqAddr   <= AddressLista;
                  state     <= LOOKUP;
               end
            end

            LOOKUP: begin
               waitCount <= '0;
               ackSeen   <= 2'b00;
               RespProc  <= reqProcL;
               if (!addrValid) begin
                  RespValid     <= 1'b1;
                  AddressMemory <= 4'd0;
                  DataMemory    <= 4'd0;
                  state         <= RESPOND;
               end else if (isOwner) begin
                  RespValid     <= 1'b1;
                  AddressMemory <= reqAddr;
                  DataMemory    <= memData[reqAddr];
                  state         <= RESPOND;
               end else if (curState == MODIFIED) begin
                  // Another processor owns the block: fetch it back before answering.
                  InvValid    <= 1'b1;
                  FetchReq    <= 1'b1;
                  InvTarget   <= curSharers;
                  InvAddress  <= reqAddr;
                  waitMask    <= curSharers;
                  pendState   <= (reqSignal == SIG_READ) ? SHARED : MODIFIED;
                  pendSharers <= (reqSignal == SIG_READ) ? (curSharers | reqMask) : reqMask;
                  state       <= FETCH;
               end else if ((reqSignal != SIG_READ) && (curState == SHARED) && (otherSharers != 2'b00)) begin
                  InvValid    <= 1'b1;
                  FetchReq    <= 1'b0;
                  InvTarget   <= otherSharers;
                  InvAddress  <= reqAddr;
                  waitMask    <= otherSharers;
                  pendState   <= MODIFIED;
                  pendSharers <= reqMask;
                  state       <= INVAL;
               end else begin
                  dirState[reqAddr]   <= (reqSignal == SIG_READ) ? SHARED : MODIFIED;
                  dirSharers[reqAddr] <= (reqSignal == SIG_READ) ? (curSharers | reqMask) : reqMask;
                  RespValid           <= 1'b1;
                  AddressMemory       <= reqAddr;
                  DataMemory          <= memData[reqAddr];
                  state               <= RESPOND;
               end
            end

            INVAL: begin
               InvValid   <= 1'b0;
               InvTarget  <= 2'b00;
               InvAddress <= 4'd0;
               ackSeen    <= ackSeen | InvAck;
               state      <= WAIT_ACK;
            end

            FETCH: begin
               InvValid   <= 1'b0;
               FetchReq   <= 1'b0;
               InvTarget  <= 2'b00;
               InvAddress <= 4'd0;
               state      <= WAIT_WB;
            end

            WAIT_ACK: begin
               if (acksDone || timedOut) begin
                  if (!acksDone) begin
                     ErrFlag <= 1'b1;
                  end
                  waitCount           <= '0;
                  dirState[reqAddr]   <= pendState;
                  dirSharers[reqAddr] <= pendSharers;
                  RespValid           <= 1'b1;
                  AddressMemory       <= reqAddr;
                  DataMemory          <= memData[reqAddr];
                  state               <= RESPOND;
               end else begin
                  waitCount <= waitCount + 1'b1;
                  ackSeen   <= ackSeen | InvAck;
               end
            end

            WAIT_WB: begin
               if (wbMatch) begin
                  memData[reqAddr]    <= DataLista;
                  dirState[reqAddr]   <= pendState;
                  dirSharers[reqAddr] <= pendSharers;
                  waitCount           <= '0;
                  RespValid           <= 1'b1;
                  AddressMemory       <= reqAddr;
                  DataMemory          <= DataLista;
                  state               <= RESPOND;
               end else begin
                  // A stray write-back still lands in memory and drops that block to Uncached.
                  if (wbValid && wbAddrValid) begin
                     memData[AddressLista]    <= DataLista;
                     dirState[AddressLista]   <= UNCACHED;
                     dirSharers[AddressLista] <= 2'b00;
                  end
                  if (timedOut) begin
                     ErrFlag             <= 1'b1;
                     waitCount           <= '0;
                     dirState[reqAddr]   <= pendState;
                     dirSharers[reqAddr] <= pendSharers;
                     RespValid           <= 1'b1;
                     AddressMemory       <= reqAddr;
                     DataMemory          <= memData[reqAddr];
                     state               <= RESPOND;
                  end else begin
                     waitCount <= waitCount + 1'b1;
                  end
               end
            end

            RESPOND: begin
               RespValid <= 1'b0;
               state     <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
